// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path: channel FSM states,
// button indices and the channel counter sizing helper.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRS_WAIT,
        ST_HELD,
        ST_REPEAT,
        ST_REL_WAIT
    } btn_state_t;

    localparam int BTN_L = 0;
    localparam int BTN_D = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    localparam int N_BTN_DEF = BTN_C + 1;
    localparam logic [4:0] RPT_MASK_DEF = (5'b1 << BTN_D) | (5'b1 << BTN_U);

    // One extra bit over the largest terminal count keeps the counter from ever wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-driven debounce FSM, registered
// press/release strobes and hold-to-auto-repeat.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | button released and accepted as released
// PRS_WAIT    | input high, waiting DEB_TICKS of stability to accept press
// HELD        | press accepted, timing the hold before the first repeat
// REPEAT      | auto-repeating every RPT_TICKS while still held
// REL_WAIT    | input low, waiting DEB_TICKS of stability to accept release
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_TICKS  = 10,
    parameter int HOLD_TICKS = 500,
    parameter int RPT_TICKS  = 100,
    parameter bit RPT_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int CW = cnt_width(DEB_TICKS, HOLD_TICKS, RPT_TICKS);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    sync;
    logic          s;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    assign s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // A change on s always wins over a tick arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            rpt   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state <= ST_PRS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRS_WAIT: begin
                    if (!s) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (cnt == DEB_LAST) begin
                            state <= ST_HELD;
                            cnt   <= '0;
                            press <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state <= ST_REL_WAIT;
                        cnt   <= '0;
                    end else if (tick) begin
                        // Without repeat enabled the hold count parks at its last value.
                        if (cnt == HOLD_LAST) begin
                            if (RPT_EN) begin
                                state <= ST_REPEAT;
                                cnt   <= '0;
                                rpt   <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!s) begin
                        state <= ST_REL_WAIT;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == RPT_LAST) begin
                            cnt <= '0;
                            rpt <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                ST_REL_WAIT: begin
                    // A bounce back high returns to HELD without a new press strobe.
                    if (s) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == DEB_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            rel   <= 1'b1;
                            level <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Push-button event generator: shared timebase tick plus one conditioning
// channel per button, with a combined press/repeat indicator.
module btn_event_gen
    import btn_pkg::*;
#(
    parameter int               N_BTN       = N_BTN_DEF,
    parameter int               TICK_CYCLES = 100000,
    parameter int               DEB_TICKS   = 10,
    parameter int               HOLD_TICKS  = 500,
    parameter int               RPT_TICKS   = 100,
    parameter logic [N_BTN-1:0] RPT_MASK    = N_BTN'(RPT_MASK_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_rel,
    output logic [N_BTN-1:0] btn_rpt,
    output logic             any_press
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEB_TICKS (DEB_TICKS),
            .HOLD_TICKS(HOLD_TICKS),
            .RPT_TICKS (RPT_TICKS),
            .RPT_EN    (RPT_MASK[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .tick (tick),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_rel[i]),
            .rpt  (btn_rpt[i])
        );
    end

    assign any_press = |(btn_press | btn_rpt);

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: expected strobes (channel, kind, cycle) are queued as
// stimulus is driven and matched against DUT strobes sampled on the falling edge.
module tb_btn_event_gen;

    localparam int N      = 5;
    localparam int TC     = 4;
    localparam int K_PRS  = 0;
    localparam int K_REL  = 1;
    localparam int K_RPT  = 2;

    typedef struct {
        int ch;
        int kind;
        int t;
    } ev_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_rel;
    logic [N-1:0] btn_rpt;
    logic         any_press;

    int  cyc = 0;
    int  r_edge = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 0;
    ev_t sb[$];

    btn_event_gen #(
        .N_BTN      (N),
        .TICK_CYCLES(TC),
        .DEB_TICKS  (3),
        .HOLD_TICKS (5),
        .RPT_TICKS  (2),
        .RPT_MASK   (5'b00110)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_rel  (btn_rel),
        .btn_rpt  (btn_rpt),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int ch, input int kind, input int t);
        ev_t e;
        e.ch   = ch;
        e.kind = kind;
        e.t    = t;
        sb.push_back(e);
    endtask

    // Tick edges fall every TC edges after the last edge that sampled rst high.
    function automatic int nth_tick(input int after, input int k);
        int d;
        d = after - r_edge;
        return r_edge + TC * (d / TC + 1) + TC * (k - 1);
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_PRS:   return "press";
            K_REL:   return "rel";
            default: return "rpt";
        endcase
    endfunction

    always @(negedge clk) begin : mon_blk
        bit ap_exp;
        bit obs;
        bit hit;
        int idx;
        if (mon_en) begin
            ap_exp = 1'b0;
            for (int ch = 0; ch < N; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    case (k)
                        K_PRS:   obs = btn_press[ch];
                        K_REL:   obs = btn_rel[ch];
                        default: obs = btn_rpt[ch];
                    endcase
                    hit = 1'b0;
                    idx = 0;
                    foreach (sb[i]) begin
                        if (!hit && sb[i].ch == ch && sb[i].kind == k && sb[i].t == cyc) begin
                            hit = 1'b1;
                            idx = i;
                        end
                    end
                    if (hit) sb.delete(idx);
                    if (obs || hit)
                        check_eq($sformatf("%s[%0d]", kname(k), ch), 32'(obs), 32'(hit));
                    if (hit && k != K_REL) ap_exp = 1'b1;
                end
            end
            check_eq("any_press", 32'(any_press), 32'(ap_exp));
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_level"}, 32'(btn_level), 32'd0);
        check_eq({tag, "_press"}, 32'(btn_press), 32'd0);
        check_eq({tag, "_rel"},   32'(btn_rel),   32'd0);
        check_eq({tag, "_rpt"},   32'(btn_rpt),   32'd0);
        check_eq({tag, "_any"},   32'(any_press), 32'd0);
    endtask

    // Drop the given bits now and queue their release strobes.
    task automatic release_bits(input logic [N-1:0] bits);
        int n;
        btn_raw = btn_raw & ~bits;
        n = cyc + 1;
        for (int ch = 0; ch < N; ch++)
            if (bits[ch]) push_ev(ch, K_REL, nth_tick(n + 2, 3));
    endtask

    initial begin
        int n;
        int p;
        int p2;
        int t;

        rst     = 1'b1;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        r_edge = cyc;
        mon_en = 1'b1;

        // 1: clean press on L, no repeat on a masked-off channel
        @(negedge clk);
        btn_raw[0] = 1'b1;
        n = cyc + 1;
        push_ev(0, K_PRS, nth_tick(n + 2, 3));
        repeat (40) @(negedge clk);
        check_eq("t1_level_held", 32'(btn_level), 32'h01);
        release_bits(5'b00001);
        repeat (20) @(negedge clk);
        check_eq("t1_level_rel", 32'(btn_level), 32'h00);

        // 2: bounce on D never long enough to accept
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_eq("t2_level", 32'(btn_level), 32'h00);

        // 3: hold U, auto-repeat, release
        btn_raw[2] = 1'b1;
        n = cyc + 1;
        p = nth_tick(n + 2, 3);
        push_ev(2, K_PRS, p);
        for (t = p + 20; t < n + 200 + 2; t += 8) push_ev(2, K_RPT, t);
        repeat (100) @(negedge clk);
        check_eq("t3_level_held", 32'(btn_level), 32'h04);
        repeat (100) @(negedge clk);
        release_bits(5'b00100);
        repeat (20) @(negedge clk);
        check_eq("t3_level_rel", 32'(btn_level), 32'h00);

        // 4: short release glitch on R while held
        btn_raw[3] = 1'b1;
        n = cyc + 1;
        push_ev(3, K_PRS, nth_tick(n + 2, 3));
        repeat (25) @(negedge clk);
        btn_raw[3] = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t4_level_glitch", 32'(btn_level), 32'h08);
        @(negedge clk);
        btn_raw[3] = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("t4_level_after", 32'(btn_level), 32'h08);
        release_bits(5'b01000);
        repeat (20) @(negedge clk);

        // 5: L and C pressed in the same cycle
        btn_raw[0] = 1'b1;
        btn_raw[4] = 1'b1;
        n = cyc + 1;
        push_ev(0, K_PRS, nth_tick(n + 2, 3));
        push_ev(4, K_PRS, nth_tick(n + 2, 3));
        repeat (25) @(negedge clk);
        check_eq("t5_level", 32'(btn_level), 32'h11);
        release_bits(5'b10001);
        repeat (20) @(negedge clk);

        // 6: reset pulse while U is repeating, button kept high
        btn_raw[2] = 1'b1;
        n = cyc + 1;
        p = nth_tick(n + 2, 3);
        push_ev(2, K_PRS, p);
        push_ev(2, K_RPT, p + 20);
        while (cyc < p + 22) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t6_rst");
        rst    = 1'b0;
        r_edge = cyc;
        p2 = nth_tick(r_edge + 3, 3);
        push_ev(2, K_PRS, p2);
        push_ev(2, K_RPT, p2 + 20);
        push_ev(2, K_RPT, p2 + 28);
        while (cyc < p2 + 30) @(negedge clk);
        check_eq("t6_level_held", 32'(btn_level), 32'h04);
        release_bits(5'b00100);
        repeat (25) @(negedge clk);
        check_eq("t6_level_rel", 32'(btn_level), 32'h00);

        mon_en = 1'b0;
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
